// File: rtl/rect_scheduler_if.sv
// Box-list write port of the rectangle scheduler: valid/ready transfer of one
// box per beat, with box_last marking the end of a frame's list.
interface rect_scheduler_if #(
    parameter int PW = 12,
    parameter int PH = 12
);
    logic          box_valid;
    logic          box_ready;
    logic [PW-1:0] box_x;
    logic [PW-1:0] box_w;
    logic [PH-1:0] box_y;
    logic [PH-1:0] box_h;
    logic          box_last;

    modport master (
        output box_valid, box_x, box_w, box_y, box_h, box_last,
        input  box_ready
    );

    modport slave (
        input  box_valid, box_x, box_w, box_y, box_h, box_last,
        output box_ready
    );
endinterface

// File: rtl/rect_scheduler.sv
// Double-buffered box table feeding N_ENG draw engines. Banks swap on vsync
// falling, and boxes are paged through the engines on successive frames.
module rect_scheduler #(
    parameter int PW      = 12,
    parameter int PH      = 12,
    parameter int MAX_BOX = 16,
    parameter int N_ENG   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PW-1:0]               pic_width,
    input  logic [PH-1:0]               pic_height,
    input  logic                        vsync,
    rect_scheduler_if.slave             box,
    output logic [N_ENG*PW-1:0]         eng_x,
    output logic [N_ENG*PW-1:0]         eng_w,
    output logic [N_ENG*PH-1:0]         eng_y,
    output logic [N_ENG*PH-1:0]         eng_h,
    output logic [N_ENG-1:0]            eng_en,
    output logic [$clog2(MAX_BOX):0]    disp_count,
    output logic                        ovf,
    output logic                        busy
);
    localparam int AW    = $clog2(MAX_BOX);
    localparam int CNT_W = AW + 1;
    localparam int RC_W  = $clog2(N_ENG + 1);
    localparam int DW    = 2 * PW + 2 * PH;
    localparam int H_LSB = 0;
    localparam int W_LSB = PH;
    localparam int Y_LSB = PH + PW;
    localparam int X_LSB = 2 * PH + PW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic             vsync_d1_reg;
    logic             pending_reg;
    logic             disp_bank_reg;
    logic [CNT_W-1:0] wr_count_reg;
    logic [CNT_W-1:0] disp_count_reg;
    logic [CNT_W-1:0] base_reg;
    logic             ovf_reg;
    logic [1:0]       state_reg;
    logic [RC_W-1:0]  rd_cnt_reg;
    logic             rd_vld_reg;
    logic [RC_W-1:0]  rd_slot_reg;
    logic [DW-1:0]    rd_data_reg;
    logic [DW-1:0]    shadow_reg [0:N_ENG-1];
    logic [DW-1:0]    mem [0:2*MAX_BOX-1];

    logic boundary, xfer, commit_ev, in_range, wr_full, store, rd_en;
    logic [PW:0]      x_end;
    logic [PH:0]      y_end;
    logic [PW-1:0]    clip_w;
    logic [PH-1:0]    clip_h;
    logic [AW:0]      wr_addr, rd_addr;
    logic [AW-1:0]    rd_idx;
    logic [CNT_W:0]   base_inc;
    logic [CNT_W-1:0] base_next;
    logic [N_ENG-1:0]    en_next;
    logic [N_ENG*PW-1:0] x_next, w_next;
    logic [N_ENG*PH-1:0] y_next, h_next;

    assign boundary      = vsync_d1_reg & ~vsync;
    assign box.box_ready = ~pending_reg;
    assign xfer          = box.box_valid & ~pending_reg;
    // box_last commits even without a valid box, so an empty list is legal
    assign commit_ev     = box.box_last & ~pending_reg;

    // Extended sums so a box reaching past the picture edge cannot wrap
    assign x_end    = {1'b0, box.box_x} + {1'b0, box.box_w};
    assign y_end    = {1'b0, box.box_y} + {1'b0, box.box_h};
    assign in_range = (box.box_x < pic_width) && (box.box_y < pic_height);
    assign clip_w   = (x_end >= {1'b0, pic_width})  ? pic_width  - box.box_x - PW'(1) : box.box_w;
    assign clip_h   = (y_end >= {1'b0, pic_height}) ? pic_height - box.box_y - PH'(1) : box.box_h;
    assign wr_full  = (wr_count_reg == CNT_W'(MAX_BOX));
    assign store    = xfer & in_range & ~wr_full;
    assign wr_addr  = {~disp_bank_reg, wr_count_reg[AW-1:0]};

    assign rd_en   = (state_reg == S_LOAD);
    assign rd_idx  = base_reg[AW-1:0] + AW'(rd_cnt_reg);
    assign rd_addr = {disp_bank_reg, rd_idx};

    assign base_inc  = {1'b0, base_reg} + (CNT_W+1)'(N_ENG);
    assign base_next = (base_inc >= {1'b0, disp_count_reg}) ? '0 : base_inc[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (store)
            mem[wr_addr] <= {box.box_x, box.box_y, clip_w, clip_h};
        if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d1_reg   <= 1'b0;
            pending_reg    <= 1'b0;
            disp_bank_reg  <= 1'b0;
            wr_count_reg   <= '0;
            disp_count_reg <= '0;
            base_reg       <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            vsync_d1_reg <= vsync;
            if (boundary && pending_reg) begin
                disp_bank_reg  <= ~disp_bank_reg;
                disp_count_reg <= wr_count_reg;
                wr_count_reg   <= '0;
                base_reg       <= '0;
                pending_reg    <= 1'b0;
                ovf_reg        <= 1'b0;
            end else begin
                if (boundary)
                    base_reg <= base_next;
                if (commit_ev)
                    pending_reg <= 1'b1;
                if (store)
                    wr_count_reg <= wr_count_reg + CNT_W'(1);
                if (xfer && in_range && wr_full)
                    ovf_reg <= 1'b1;
            end
        end
    end

    // A boundary always (re)starts the load, even mid-load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            rd_cnt_reg  <= '0;
            rd_vld_reg  <= 1'b0;
            rd_slot_reg <= '0;
        end else begin
            rd_vld_reg  <= rd_en;
            rd_slot_reg <= rd_cnt_reg;
            if (boundary) begin
                state_reg  <= S_LOAD;
                rd_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    S_LOAD: begin
                        rd_cnt_reg <= rd_cnt_reg + RC_W'(1);
                        if (rd_cnt_reg == RC_W'(N_ENG - 1))
                            state_reg <= S_COMMIT;
                    end
                    S_COMMIT: state_reg <= S_IDLE;
                    default:  state_reg <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ENG; i++)
            if (rd_vld_reg && rd_slot_reg == RC_W'(i))
                shadow_reg[i] <= rd_data_reg;
    end

    generate
        for (genvar gi = 0; gi < N_ENG; gi++) begin : g_eng
            logic [DW-1:0] src;
            // The final read is still in the RAM output register at commit time
            if (gi == N_ENG - 1) begin : g_last
                assign src = rd_data_reg;
            end else begin : g_shadow
                assign src = shadow_reg[gi];
            end
            assign en_next[gi] = ({1'b0, base_reg} + (CNT_W+1)'(gi)) < {1'b0, disp_count_reg};
            assign x_next[gi*PW +: PW] = en_next[gi] ? src[X_LSB +: PW] : '0;
            assign w_next[gi*PW +: PW] = en_next[gi] ? src[W_LSB +: PW] : '0;
            assign y_next[gi*PH +: PH] = en_next[gi] ? src[Y_LSB +: PH] : '0;
            assign h_next[gi*PH +: PH] = en_next[gi] ? src[H_LSB +: PH] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_x  <= '0;
            eng_w  <= '0;
            eng_y  <= '0;
            eng_h  <= '0;
            eng_en <= '0;
        end else if (state_reg == S_COMMIT) begin
            eng_x  <= x_next;
            eng_w  <= w_next;
            eng_y  <= y_next;
            eng_h  <= h_next;
            eng_en <= en_next;
        end
    end

    assign disp_count = disp_count_reg;
    assign ovf        = ovf_reg;
    assign busy       = (state_reg != S_IDLE);
endmodule

// File: tb/tb_rect_scheduler.sv
// Scoreboard bench for rect_scheduler: a list/paging model predicts the engine
// contents of every frame, which are compared once the load completes.
module tb_rect_scheduler;
    localparam int PW = 12, PH = 12, MAX_BOX = 16, N_ENG = 4;
    localparam int CNT_W = $clog2(MAX_BOX) + 1;

    typedef struct packed {
        logic [PW-1:0] x;
        logic [PH-1:0] y;
        logic [PW-1:0] w;
        logic [PH-1:0] h;
    } box_t;

    typedef struct packed {
        logic en;
        box_t b;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                vsync;
    logic [PW-1:0]       pic_width;
    logic [PH-1:0]       pic_height;
    logic [N_ENG*PW-1:0] eng_x, eng_w;
    logic [N_ENG*PH-1:0] eng_y, eng_h;
    logic [N_ENG-1:0]    eng_en;
    logic [CNT_W-1:0]    disp_count;
    logic                ovf, busy;

    rect_scheduler_if #(.PW(PW), .PH(PH)) bif ();

    rect_scheduler #(.PW(PW), .PH(PH), .MAX_BOX(MAX_BOX), .N_ENG(N_ENG)) dut (
        .clk        (clk),
        .rst        (rst),
        .pic_width  (pic_width),
        .pic_height (pic_height),
        .vsync      (vsync),
        .box        (bif),
        .eng_x      (eng_x),
        .eng_w      (eng_w),
        .eng_y      (eng_y),
        .eng_h      (eng_h),
        .eng_en     (eng_en),
        .disp_count (disp_count),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    box_t             wr_q[$];
    box_t             disp_q[$];
    exp_t             exp_q[$];
    bit               m_pending;
    bit               m_ovf;
    int               m_page;
    logic [N_ENG-1:0] m_en_shown;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic box_t mk(input int x, input int y, input int w, input int h);
        box_t b;
        b.x = PW'(x);
        b.y = PH'(y);
        b.w = PW'(w);
        b.h = PH'(h);
        return b;
    endfunction

    // Reference clip: reject off-picture origins, trim extents to the last pixel
    function automatic bit clip_box(input box_t in, output box_t o);
        o = in;
        if (int'(in.x) >= int'(pic_width) || int'(in.y) >= int'(pic_height))
            return 1'b0;
        if (int'(in.x) + int'(in.w) > int'(pic_width) - 1)
            o.w = PW'(int'(pic_width) - 1 - int'(in.x));
        if (int'(in.y) + int'(in.h) > int'(pic_height) - 1)
            o.h = PH'(int'(pic_height) - 1 - int'(in.y));
        return 1'b1;
    endfunction

    function automatic void model_reset();
        wr_q.delete();
        disp_q.delete();
        exp_q.delete();
        m_pending  = 1'b0;
        m_ovf      = 1'b0;
        m_page     = 0;
        m_en_shown = '0;
    endfunction

    function automatic void model_boundary();
        exp_t e;
        int   np;
        if (m_pending) begin
            disp_q = wr_q;
            wr_q.delete();
            m_page    = 0;
            m_pending = 1'b0;
            m_ovf     = 1'b0;
        end else begin
            np = (disp_q.size() + N_ENG - 1) / N_ENG;
            if (np == 0) np = 1;
            m_page = (m_page + 1) % np;
        end
        for (int i = 0; i < N_ENG; i++) begin
            int idx = m_page * N_ENG + i;
            e.en = (idx < disp_q.size());
            e.b  = e.en ? disp_q[idx] : '0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic send(input logic v, input box_t b, input logic last);
        box_t o;
        int   guard = 0;
        while (bif.box_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL send_ready: box_ready=%b required 1", bif.box_ready);
        end
        bif.box_valid = v;
        bif.box_x = b.x; bif.box_y = b.y; bif.box_w = b.w; bif.box_h = b.h;
        bif.box_last = last;
        if (v && clip_box(b, o)) begin
            if (wr_q.size() == MAX_BOX) m_ovf = 1'b1;
            else wr_q.push_back(o);
        end
        if (last) m_pending = 1'b1;
        $display("send v=%0b (%0d,%0d,%0d,%0d) last=%0b wr_model=%0d", v, b.x, b.y, b.w, b.h, last, wr_q.size());
        @(posedge clk); #1;
        bif.box_valid = 1'b0;
        bif.box_last  = 1'b0;
    endtask

    // vsync pulse; optionally box_last on the boundary cycle itself
    task automatic frame(input bit with_last, input string tag);
        exp_t             e, got;
        logic [N_ENG-1:0] en_exp;
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
        if (with_last) begin
            bif.box_valid = 1'b0;
            bif.box_last  = 1'b1;
        end
        model_boundary();
        if (with_last) m_pending = 1'b1;
        @(posedge clk); #1 bif.box_last = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_t1: got %b required 1", tag, busy); end
        n_cmp++;
        if (disp_count !== CNT_W'(disp_q.size())) begin
            n_bad++; $display("FAIL %s disp_count: got %0d required %0d", tag, disp_count, disp_q.size());
        end
        n_cmp++;
        if (ovf !== m_ovf) begin n_bad++; $display("FAIL %s ovf_after_swap: got %b required %b", tag, ovf, m_ovf); end
        n_cmp++;
        if (bif.box_ready !== !m_pending) begin
            n_bad++; $display("FAIL %s box_ready: got %b required %b", tag, bif.box_ready, !m_pending);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || eng_en !== m_en_shown) begin
            n_bad++; $display("FAIL %s commit_early: busy=%b eng_en=%b required busy=1 eng_en=%b", tag, busy, eng_en, m_en_shown);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_done: got %b required 0", tag, busy); end
        for (int i = 0; i < N_ENG; i++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++; $display("FAIL %s scoreboard_empty: engine %0d has no expected entry", tag, i);
            end else begin
                e = exp_q.pop_front();
                en_exp[i] = e.en;
                got.en = eng_en[i];
                got.b  = {eng_x[i*PW +: PW], eng_y[i*PH +: PH], eng_w[i*PW +: PW], eng_h[i*PH +: PH]};
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL %s eng%0d: got en=%b (%0d,%0d,%0d,%0d) required en=%b (%0d,%0d,%0d,%0d)",
                             tag, i, got.en, got.b.x, got.b.y, got.b.w, got.b.h, e.en, e.b.x, e.b.y, e.b.w, e.b.h);
                end
            end
        end
        m_en_shown = en_exp;
        $display("frame %s: eng_en=%b disp_count=%0d page=%0d", tag, eng_en, disp_count, m_page);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({eng_x, eng_y, eng_w, eng_h, eng_en, disp_count, ovf, busy} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: eng_en=%b disp_count=%0d ovf=%b busy=%b required all 0", eng_en, disp_count, ovf, busy);
        end
        n_cmp++;
        if (bif.box_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", bif.box_ready); end
    endtask

    task automatic test_basic_load();
        send(1'b1, mk(10, 20, 30, 40), 1'b0);
        send(1'b1, mk(100, 50, 8, 8), 1'b0);
        send(1'b1, mk(0, 0, 5, 5), 1'b1);
        frame(1'b0, "basic");
        n_cmp++;
        if (eng_en !== 4'b0111 || eng_x[0 +: PW] !== 12'd10 || eng_h[0 +: PH] !== 12'd40) begin
            n_bad++; $display("FAIL basic_direct: eng_en=%b x0=%0d h0=%0d required 0111 10 40", eng_en, eng_x[0 +: PW], eng_h[0 +: PH]);
        end
    endtask

    task automatic test_reset_mid_load();
        send(1'b1, mk(1, 2, 3, 4), 1'b1);
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({eng_x, eng_y, eng_w, eng_h, eng_en, disp_count, ovf, busy} !== '0) begin
            n_bad++; $display("FAIL midload_reset_outputs: eng_en=%b disp_count=%0d ovf=%b busy=%b required all 0", eng_en, disp_count, ovf, busy);
        end
        n_cmp++;
        if (bif.box_ready !== 1'b1) begin n_bad++; $display("FAIL midload_reset_ready: got %b required 1", bif.box_ready); end
    endtask

    task automatic test_paging();
        for (int i = 0; i < 6; i++)
            send(1'b1, mk(20 * i + 1, 10 * i + 2, i + 3, i + 4), (i == 5));
        frame(1'b0, "page_f1");
        frame(1'b0, "page_f2");
        n_cmp++;
        if (eng_en !== 4'b0011) begin n_bad++; $display("FAIL paging_f2_en: got %b required 0011", eng_en); end
        frame(1'b0, "page_f3");
    endtask

    task automatic test_clipping();
        send(1'b1, mk(600, 10, 100, 10), 1'b0);
        send(1'b1, mk(640, 10, 5, 5), 1'b0);
        send(1'b1, mk(10, 470, 5, 20), 1'b0);
        send(1'b1, mk(639, 479, 0, 0), 1'b1);
        frame(1'b0, "clip");
        n_cmp++;
        if (eng_w[0 +: PW] !== 12'd39 || disp_count !== 5'd3) begin
            n_bad++; $display("FAIL clip_direct: w0=%0d disp_count=%0d required 39 3", eng_w[0 +: PW], disp_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++)
            send(1'b1, mk(i * 7, i * 5, 9, 9), (i == 17));
        @(negedge clk);
        n_cmp++;
        if (ovf !== m_ovf || ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_before_swap: got %b required 1", ovf); end
        frame(1'b0, "ovf");
    endtask

    task automatic test_deferred_commit();
        send(1'b1, mk(5, 6, 7, 8), 1'b0);
        send(1'b1, mk(50, 60, 70, 80), 1'b0);
        frame(1'b1, "defer_a");
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bif.box_ready !== 1'b0) begin n_bad++; $display("FAIL defer_ready_held: got %b required 0", bif.box_ready); end
        frame(1'b0, "defer_b");
    endtask

    task automatic test_empty_commit();
        send(1'b0, mk(0, 0, 0, 0), 1'b1);
        frame(1'b0, "empty");
        n_cmp++;
        if (eng_en !== 4'b0000) begin n_bad++; $display("FAIL empty_en: got %b required 0000", eng_en); end
    endtask

    initial begin
        rst = 1'b1;
        vsync = 1'b0;
        pic_width = 12'd640;
        pic_height = 12'd480;
        bif.box_valid = 1'b0;
        bif.box_last = 1'b0;
        bif.box_x = '0; bif.box_y = '0; bif.box_w = '0; bif.box_h = '0;
        test_reset();
        test_basic_load();
        test_reset_mid_load();
        test_paging();
        test_clipping();
        test_overflow();
        test_deferred_commit();
        test_empty_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
